// File: rtl/accessory_input_sequencer.sv
// PL19 accessory input sequencer: character FIFO feeding an MSB-first serializer.
// Optional build macro ACC_STOP_CODE_EN enables stop-code detection and the stop_seen pulse.
module accessory_input_sequencer #(
    parameter int                CHAR_W    = 5,
    parameter int                DEPTH     = 16,
    parameter logic [CHAR_W-1:0] STOP_CODE = CHAR_W'(5'b10000)
) (
    input  logic                     CLOCK,
    input  logic                     rst,
    input  logic                     char_valid,
    input  logic [CHAR_W-1:0]        char_data,
    output logic                     char_ready,
    input  logic                     flush,
    input  logic                     PL19_START_INPUT,
    input  logic                     PL19_STOP_INPUT,
    input  logic                     PL19_SHIFT_CMD_M20,
    output logic                     PL19_INPUT,
    output logic                     active,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     underrun,
    input  logic                     underrun_clr,
    output logic                     stop_seen
);

    localparam int             AW       = $clog2(DEPTH);
    localparam int             BW       = (CHAR_W > 1) ? $clog2(CHAR_W) : 1;
    localparam logic [BW-1:0]  LAST_BIT = BW'(CHAR_W - 1);

    typedef enum logic [1:0] {IDLE, ARMED, SHIFT} state_t;

    state_t             state, state_n;
    logic [CHAR_W-1:0]  shreg, shreg_n;
    logic [BW-1:0]      bitcnt, bitcnt_n;
    logic               pop;
    logic               underrun_set;

    logic [CHAR_W-1:0]  mem [DEPTH];
    logic [AW:0]        wr_ptr, rd_ptr;
    logic               full, empty, push;
    logic [CHAR_W-1:0]  head;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty      = (wr_ptr == rd_ptr);
    assign full       = ((wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}});
    assign char_ready = ~full;
    assign push       = char_valid & ~full;
    assign fifo_count = wr_ptr - rd_ptr;
    assign head       = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge CLOCK) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= char_data;
        end
    end

    always_ff @(posedge CLOCK) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

`ifdef ACC_STOP_CODE_EN
    logic [CHAR_W-1:0] cur_char, cur_char_n;
    logic              stop_hit;
    logic              stop_q;

    always_ff @(posedge CLOCK) begin
        if (rst) begin
            cur_char <= '0;
            stop_q   <= 1'b0;
        end else begin
            cur_char <= cur_char_n;
            stop_q   <= stop_hit;
        end
    end

    assign stop_seen = stop_q;
`else
    logic unused_stop_code;
    assign unused_stop_code = ^STOP_CODE;
    assign stop_seen        = 1'b0;
`endif

    always_ff @(posedge CLOCK) begin
        if (rst) begin
            state  <= IDLE;
            shreg  <= '0;
            bitcnt <= '0;
        end else begin
            state  <= state_n;
            shreg  <= shreg_n;
            bitcnt <= bitcnt_n;
        end
    end

    always_comb begin
        state_n      = state;
        shreg_n      = shreg;
        bitcnt_n     = bitcnt;
        pop          = 1'b0;
        underrun_set = 1'b0;
`ifdef ACC_STOP_CODE_EN
        cur_char_n   = cur_char;
        stop_hit     = 1'b0;
`endif
        if (PL19_STOP_INPUT) begin
            state_n  = IDLE;
            shreg_n  = '0;
            bitcnt_n = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (PL19_START_INPUT) state_n = ARMED;
                end
                ARMED: begin
                    // An ARMED slot always delivers 0, even when a load happens on the same edge.
                    if (PL19_SHIFT_CMD_M20) underrun_set = 1'b1;
                    if (!empty) begin
                        pop      = 1'b1;
                        shreg_n  = head;
                        bitcnt_n = '0;
                        state_n  = SHIFT;
`ifdef ACC_STOP_CODE_EN
                        cur_char_n = head;
`endif
                    end
                end
                SHIFT: begin
                    if (PL19_SHIFT_CMD_M20) begin
                        shreg_n  = shreg << 1;
                        bitcnt_n = bitcnt + 1'b1;
                        if (bitcnt == LAST_BIT) begin
                            bitcnt_n = '0;
`ifdef ACC_STOP_CODE_EN
                            if (cur_char == STOP_CODE) begin
                                state_n  = IDLE;
                                shreg_n  = '0;
                                stop_hit = 1'b1;
                            end else
`endif
                            if (!empty) begin
                                pop     = 1'b1;
                                shreg_n = head;
`ifdef ACC_STOP_CODE_EN
                                cur_char_n = head;
`endif
                            end else begin
                                state_n = ARMED;
                            end
                        end
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLOCK) begin
        if (rst) begin
            underrun <= 1'b0;
        end else if (underrun_set) begin
            underrun <= 1'b1;
        end else if (underrun_clr) begin
            underrun <= 1'b0;
        end
    end

    assign PL19_INPUT = (state == SHIFT) ? shreg[CHAR_W-1] : 1'b0;
    assign active     = (state != IDLE);

endmodule

// File: doc/accessory_input_sequencer.md
Name: accessory_input_sequencer

Overview:
- Accessory-side sequencer for the PL19 input path of the control switch.
- Buffers host-supplied characters in a FIFO. Arms on PL19_START_INPUT and disarms on PL19_STOP_INPUT.
- Serializes characters MSB-first onto PL19_INPUT, one bit per CLOCK edge on which PL19_SHIFT_CMD_M20 is high.
- Tracks underrun (bit slot requested with no data ready). Lets photo-tape/typewriter input emulation feed the machine without per-bit host involvement.

Parameters:
- CHAR_W, 5, character width in bits (1..8).
- DEPTH, 16, FIFO depth in characters; power of 2, minimum 2.
- STOP_CODE, 5'b10000, character value recognised as stop code (used only with ACC_STOP_CODE_EN).

Ports:
- CLOCK  in  1  system clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- char_valid  in  1  host offers char_data.
- char_data  in  CHAR_W  host character.
- char_ready  out  1  FIFO not full; push occurs on edge with char_valid & char_ready.
- flush  in  1  synchronous FIFO clear.
- PL19_START_INPUT  in  1  arm request from control switch.
- PL19_STOP_INPUT  in  1  disarm request from control switch.
- PL19_SHIFT_CMD_M20  in  1  bit-slot request; one bit consumed per high edge.
- PL19_INPUT  out  1  serial data to control switch.
- active  out  1  state != IDLE.
- fifo_count  out  $clog2(DEPTH)+1  characters buffered.
- underrun  out  1  sticky underrun flag.
- underrun_clr  in  1  clears underrun.
- stop_seen  out  1  one-cycle pulse (ACC_STOP_CODE_EN only).

Behaviour:
- Reset (rst high at an edge):
  - state=IDLE; FIFO empty (fifo_count=0); shift reg=0; bitcnt=0.
  - underrun=0; stop_seen=0; PL19_INPUT=0.
  - char_ready=1 once rst is low.
  - Reset mid-character discards the partial character and all buffered data.
- FIFO: circular, read and write pointers one bit wider than the index.
  - char_ready = ~full, combinational.
  - Push and pop on the same edge: count unchanged.
  - Pop only when nonempty; push only when not full.
  - flush empties the FIFO and has priority over a same-edge push. It does not change state or the shift register.
- States: IDLE, ARMED, SHIFT.
- IDLE:
  - PL19_INPUT=0.
  - PL19_START_INPUT -> ARMED.
  - PL19_SHIFT_CMD_M20 is ignored; no underrun is recorded.
- ARMED:
  - PL19_INPUT=0.
  - If FIFO nonempty: pop head into the shift register, bitcnt=0, -> SHIFT on next edge.
  - If PL19_SHIFT_CMD_M20 is high on an ARMED edge, set underrun. This applies whether or not the FIFO is empty, because that slot delivered 0.
- SHIFT:
  - PL19_INPUT = shift reg MSB, combinational, so it is valid in the same cycle as the shift command.
  - On a PL19_SHIFT_CMD_M20 edge: shift left one, bitcnt++.
  - When the consumed bit is bitcnt==CHAR_W-1 and the FIFO is nonempty: pop the next character into the shift register on the same edge, bitcnt=0, stay in SHIFT (back-to-back, no gap slot).
  - In the same case with the FIFO empty: -> ARMED.
- PL19_STOP_INPUT (any state):
  - -> IDLE on the next edge; shift reg and bitcnt cleared.
  - The FIFO is retained, so the partial character is lost but buffered characters are not.
  - STOP wins over a simultaneous START or shift.
- START while ARMED/SHIFT: ignored.
- underrun:
  - Set has priority over a same-edge underrun_clr.
  - Cleared only by underrun_clr or rst.
- active = (state != IDLE), combinational from the state register.

Optional Feature:
- ACC_STOP_CODE_EN defined:
  - When a character equal to STOP_CODE has its last bit consumed, the block goes to IDLE on that edge (no pop) and pulses stop_seen high for one cycle.
  - The remaining FIFO contents are retained.
- ACC_STOP_CODE_EN undefined:
  - No compare logic; stop_seen tied 0.
  - STOP_CODE is serialized like any other character.

Test Plan:
- Basic serialize:
  - Stimulus: push 5'b10110 and 5'b00011, pulse START, hold SHIFT_CMD_M20 high 10 cycles.
  - Response: PL19_INPUT = 1,0,1,1,0,0,0,0,1,1 on consecutive edges; then ARMED; fifo_count=0; underrun=0.
- Underrun:
  - Stimulus: START with empty FIFO, 3 shift edges.
  - Response: PL19_INPUT=0 throughout; underrun=1 after the first edge; underrun_clr clears it to 0.
- Full FIFO:
  - Stimulus: push 17 characters with DEPTH=16 while IDLE.
  - Response: char_ready=0 after the 16th push; the 17th is not accepted; fifo_count=16.
- Mid-character STOP:
  - Stimulus: push 3 characters, START, 2 shift edges, pulse STOP.
  - Response: state IDLE next edge; PL19_INPUT=0; fifo_count=2; a later START resumes with the 2nd character from its MSB.
- Simultaneous events:
  - Stimulus: START+STOP in the same cycle from IDLE.
  - Response: remains IDLE.
  - Stimulus: push and pop on the same edge at fifo_count=4.
  - Response: fifo_count stays 4.
- Stop code (ACC_STOP_CODE_EN):
  - Stimulus: push 5'b00101, 5'b10000, 5'b01111; START; continuous shift.
  - Response: 10 bits shifted; stop_seen pulses once; state IDLE; fifo_count=1.
- Reset mid-SHIFT:
  - Stimulus: assert rst mid-SHIFT.
  - Response: all outputs at reset values on the next edge.
